// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller
// Sequences the fetch-stage PC. Redirect requests (exception, branch, jump)
// and stall sources (imem wait, load-use, multiply/divide) are merged into
// the PC's jump/stall controls and the per-stage flush lines. A redirect that
// arrives while instruction memory is stalled is parked in a one-entry pending
// slot and issued on the first cycle the memory is ready.
module pc_redirect_controller #(
  parameter int unsigned          INT_WIDTH  = 32,
  parameter int unsigned          MD_LATENCY = 32,
  parameter logic [INT_WIDTH-1:0] EXC_VECTOR = INT_WIDTH'(32'h0000_0180)
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 excReq,
  input  logic                 branchReq,
  input  logic [INT_WIDTH-1:0] branchTarget,
  input  logic                 jumpReq,
  input  logic [INT_WIDTH-1:0] jumpTarget,
  input  logic                 loadUse,
  input  logic                 mdStart,
  input  logic                 imemWait,
  output logic                 jumpEnable,
  output logic [INT_WIDTH-1:0] jumpValue,
  output logic                 stall,
  output logic                 flushIF,
  output logic                 flushID,
  output logic                 flushEX,
  output logic                 mdBusy
);

  localparam int unsigned CNT_W = $clog2(MD_LATENCY + 1);

  typedef enum logic [1:0] {
    KIND_EXC = 2'd0,
    KIND_BR  = 2'd1,
    KIND_JMP = 2'd2
  } kind_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  logic                 pend_valid_q, pend_valid_d;
  logic [INT_WIDTH-1:0] pend_target_q, pend_target_d;
  kind_e                pend_kind_q, pend_kind_d;
  md_state_e            md_state_q, md_state_d;
  logic [CNT_W-1:0]     md_count_q, md_count_d;

  logic                 cand_valid;
  logic [INT_WIDTH-1:0] cand_target;
  kind_e                cand_kind;
  logic                 md_busy_now;

  assign md_busy_now = (md_state_q == MD_BUSY);

  // Pick the redirect candidate: an exception always wins, otherwise a parked
  // entry shadows new branch/jump requests (those come from a squashed path).
  always_comb begin
    cand_valid  = 1'b0;
    cand_target = '0;
    cand_kind   = KIND_JMP;
    if (excReq) begin
      cand_valid  = 1'b1;
      cand_target = EXC_VECTOR;
      cand_kind   = KIND_EXC;
    end else if (pend_valid_q) begin
      cand_valid  = 1'b1;
      cand_target = pend_target_q;
      cand_kind   = pend_kind_q;
    end else if (branchReq) begin
      cand_valid  = 1'b1;
      cand_target = branchTarget;
      cand_kind   = KIND_BR;
    end else if (jumpReq) begin
      cand_valid  = 1'b1;
      cand_target = jumpTarget;
      cand_kind   = KIND_JMP;
    end
  end

  // Drive PC controls and flushes; reset holds the pipeline frozen and flushed.
  always_comb begin
    jumpEnable = 1'b0;
    jumpValue  = '0;
    stall      = 1'b0;
    flushIF    = 1'b0;
    flushID    = 1'b0;
    flushEX    = 1'b0;
    mdBusy     = md_busy_now;
    if (!resetN) begin
      stall   = 1'b1;
      flushIF = 1'b1;
      flushID = 1'b1;
      flushEX = 1'b1;
      mdBusy  = 1'b0;
    end else if (cand_valid && !imemWait) begin
      jumpEnable = 1'b1;
      jumpValue  = cand_target;
      case (cand_kind)
        KIND_EXC: begin
          flushIF = 1'b1;
          flushID = 1'b1;
          flushEX = 1'b1;
        end
        KIND_BR: begin
          flushIF = 1'b1;
          flushID = 1'b1;
        end
        KIND_JMP: begin
          flushIF = 1'b1;
        end
        default: begin
          flushIF = 1'b0;
        end
      endcase
    end else if (cand_valid) begin
      stall = 1'b1;
    end else begin
      stall = imemWait | loadUse | md_busy_now;
    end
  end

  // Park a redirect that cannot issue because of imemWait; drop it once issued.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_kind_d   = pend_kind_q;
    if (cand_valid) begin
      if (imemWait) begin
        pend_valid_d  = 1'b1;
        pend_target_d = cand_target;
        pend_kind_d   = cand_kind;
      end else begin
        pend_valid_d = 1'b0;
      end
    end
  end

  // Multiply/divide stall counter; an exception aborts the operation outright.
  always_comb begin
    md_state_d = md_state_q;
    md_count_d = md_count_q;
    if (cand_valid && (cand_kind == KIND_EXC)) begin
      md_state_d = MD_IDLE;
      md_count_d = '0;
    end else if (md_state_q == MD_BUSY) begin
      md_count_d = md_count_q - CNT_W'(1);
      if (md_count_q == CNT_W'(1)) begin
        md_state_d = MD_IDLE;
      end
    end else if (mdStart && !cand_valid) begin
      md_state_d = MD_BUSY;
      md_count_d = CNT_W'(MD_LATENCY);
    end
  end

  // State registers; reset discards any parked redirect and MD operation.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_kind_q   <= KIND_JMP;
      md_state_q    <= MD_IDLE;
      md_count_q    <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_kind_q   <= pend_kind_d;
      md_state_q    <= md_state_d;
      md_count_q    <= md_count_d;
    end
  end

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Testbench for pc_redirect_controller: directed scenarios followed by random
// traffic, all checked against a cycle-level reference model of the PC
// sequencing rules.
module tb_pc_redirect_controller;

  localparam int          LAT      = 4;
  localparam logic [31:0] EXC_ADDR = 32'h0000_0180;

  logic        clock = 1'b0;
  logic        resetN;
  logic        excReq, branchReq, jumpReq, loadUse, mdStart, imemWait;
  logic [31:0] branchTarget, jumpTarget;
  logic        jumpEnable, stall, flushIF, flushID, flushEX, mdBusy;
  logic [31:0] jumpValue;

  int vectorsApplied = 0;
  int miscompares    = 0;

  // Reference model state: a parked redirect (target plus how many stages it
  // flushes) and the number of MD stall cycles still owed.
  bit          mPendValid;
  logic [31:0] mPendTarget;
  int          mPendLevel;
  int          mMdLeft;

  pc_redirect_controller #(
    .INT_WIDTH (32),
    .MD_LATENCY(LAT),
    .EXC_VECTOR(EXC_ADDR)
  ) dut (
    .clock       (clock),
    .resetN      (resetN),
    .excReq      (excReq),
    .branchReq   (branchReq),
    .branchTarget(branchTarget),
    .jumpReq     (jumpReq),
    .jumpTarget  (jumpTarget),
    .loadUse     (loadUse),
    .mdStart     (mdStart),
    .imemWait    (imemWait),
    .jumpEnable  (jumpEnable),
    .jumpValue   (jumpValue),
    .stall       (stall),
    .flushIF     (flushIF),
    .flushID     (flushID),
    .flushEX     (flushEX),
    .mdBusy      (mdBusy)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 clock = ~clock;

  // Compare one observed value against its expectation and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Outputs that reset must force regardless of state or clock.
  task automatic checkReset(input string tag);
    checkOutput({tag, ".jumpEnable"}, 32'(jumpEnable), 32'd0);
    checkOutput({tag, ".jumpValue"}, jumpValue, 32'd0);
    checkOutput({tag, ".stall"}, 32'(stall), 32'd1);
    checkOutput({tag, ".flushIF"}, 32'(flushIF), 32'd1);
    checkOutput({tag, ".flushID"}, 32'(flushID), 32'd1);
    checkOutput({tag, ".flushEX"}, 32'(flushEX), 32'd1);
    checkOutput({tag, ".mdBusy"}, 32'(mdBusy), 32'd0);
  endtask

  task automatic clearModel();
    mPendValid  = 1'b0;
    mPendTarget = '0;
    mPendLevel  = 0;
    mMdLeft     = 0;
  endtask

  task automatic zeroInputs();
    excReq       = 1'b0;
    branchReq    = 1'b0;
    jumpReq      = 1'b0;
    loadUse      = 1'b0;
    mdStart      = 1'b0;
    imemWait     = 1'b0;
    branchTarget = '0;
    jumpTarget   = '0;
  endtask

  // Drive one cycle of inputs after the falling edge, check the combinational
  // outputs against the model, then advance the model to match the next edge.
  task automatic applyStimulus(input bit exc, input bit br, input logic [31:0] bt,
                               input bit jmp, input logic [31:0] jt,
                               input bit lu, input bit md, input bit wt);
    bit          haveCand;
    bit          issue;
    bit          busy;
    logic [31:0] cTarget;
    int          cLevel;
    @(negedge clock);
    excReq       = exc;
    branchReq    = br;
    branchTarget = bt;
    jumpReq      = jmp;
    jumpTarget   = jt;
    loadUse      = lu;
    mdStart      = md;
    imemWait     = wt;
    #2;
    busy     = (mMdLeft > 0);
    haveCand = 1'b1;
    if (exc) begin
      cTarget = EXC_ADDR;
      cLevel  = 3;
    end else if (mPendValid) begin
      cTarget = mPendTarget;
      cLevel  = mPendLevel;
    end else if (br) begin
      cTarget = bt;
      cLevel  = 2;
    end else if (jmp) begin
      cTarget = jt;
      cLevel  = 1;
    end else begin
      haveCand = 1'b0;
      cTarget  = '0;
      cLevel   = 0;
    end
    issue = haveCand && !wt;
    checkOutput("jumpEnable", 32'(jumpEnable), 32'(issue));
    if (!(haveCand && wt)) checkOutput("jumpValue", jumpValue, issue ? cTarget : 32'd0);
    checkOutput("stall", 32'(stall), haveCand ? 32'(wt) : 32'(wt | lu | busy));
    checkOutput("flushIF", 32'(flushIF), 32'(issue && cLevel >= 1));
    checkOutput("flushID", 32'(flushID), 32'(issue && cLevel >= 2));
    checkOutput("flushEX", 32'(flushEX), 32'(issue && cLevel >= 3));
    checkOutput("mdBusy", 32'(mdBusy), 32'(busy));
    if (issue) begin
      mPendValid = 1'b0;
    end else if (haveCand) begin
      mPendValid  = 1'b1;
      mPendTarget = cTarget;
      mPendLevel  = cLevel;
    end
    if (haveCand && cLevel == 3) mMdLeft = 0;
    else if (busy) mMdLeft = mMdLeft - 1;
    else if (md && !haveCand) mMdLeft = LAT;
  endtask

  // Quiet cycle helper for readability in the directed scenarios.
  task automatic idleCycle(input bit wt);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, wt);
  endtask

  // Main sequence: reset, directed scenarios, random traffic, async reset.
  initial begin
    resetN = 1'b0;
    zeroInputs();
    clearModel();
    #2;
    checkReset("initReset");
    #10;
    resetN = 1'b1;

    $display("[TB] directed: branch beats jump");
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);

    $display("[TB] directed: jump parked during memory wait");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h240, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b0);

    $display("[TB] directed: exception overwrites parked branch");
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idleCycle(1'b0);

    $display("[TB] directed: MD stall with a repeated start");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idleCycle(1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);

    $display("[TB] directed: exception aborts MD");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idleCycle(1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom,
                    $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] async reset with parked redirect and MD busy");
    idleCycle(1'b0);
    idleCycle(1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h444, 1'b0, 1'b0, 1'b1);
    #1;
    zeroInputs();
    resetN = 1'b0;
    #1;
    checkReset("midReset");
    clearModel();
    @(posedge clock);
    @(negedge clock);
    #1;
    resetN = 1'b1;
    idleCycle(1'b0);

    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom,
                    $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
